// File: rtl/xts_pkg.sv
// rtl/xts_pkg.sv - shared constants and scheduler state encoding for the XTS AES scheduler
package xts_pkg;

    // Number of AES-256 rounds the core iterates through after a start.
    localparam logic [3:0] ROUND_COUNT = 4'd14;

    // Core input/output mux select values.
    localparam logic SEL_TWEAK = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    // Core mode values.
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // IDLE: waiting to grant; HOLD: second start cycle of a decrypt; RUN: rounds in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/xts_rr_arb2.sv
// rtl/xts_rr_arb2.sv - two-input round-robin arbiter with update-on-grant pointer
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i[1:0]   : requests, bit 0 = tweak, bit 1 = data
//   en_i         : arbitration allowed this cycle; no grant and no pointer update otherwise
//   gnt_o[1:0]   : one-hot grant, combinational in the cycle it is issued
module xts_rr_arb2
    import xts_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // prio_q names the requester that wins a tie (the one not granted last).
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (prio_q == SEL_DATA) ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o[0]) begin
            prio_d = SEL_DATA;
        end else if (gnt_o[1]) begin
            prio_d = SEL_TWEAK;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= SEL_TWEAK;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/xts_aes_scheduler.sv
// rtl/xts_aes_scheduler.sv - arbiter and round sequencer sharing one AES-256 core between tweak and data paths
//
// Ports:
//   inClk, inRst              : clock, asynchronous active-high reset
//   inTweakReq, inDataReq     : level requests; tweak is always an encrypt
//   inDataMode                : data op mode (0 enc, 1 dec), sampled at grant
//   inCoreBusy                : core counter non-zero; blocks new grants
//   outTweakGrant/outDataGrant: one-cycle grant pulse, operand must be on core input
//   outCoreStart              : core external-data-write strobe (1 cycle enc, 2 cycles dec)
//   outCoreMode, outCoreSel   : core mode and mux select, valid from grant, held until next grant
//   outTweakDone/outDataDone  : one-cycle pulse, core output register holds the result
//   outBusy                   : grant cycle through last round cycle
module xts_aes_scheduler
    import xts_pkg::*;
#(
    parameter logic [3:0] pRoundCount = ROUND_COUNT
) (
    input  logic inClk,
    input  logic inRst,
    input  logic inTweakReq,
    input  logic inDataReq,
    input  logic inDataMode,
    input  logic inCoreBusy,
    output logic outTweakGrant,
    output logic outDataGrant,
    output logic outCoreStart,
    output logic outCoreMode,
    output logic outCoreSel,
    output logic outTweakDone,
    output logic outDataDone,
    output logic outBusy
);

    sched_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         sel_q, sel_d;
    logic         mode_q, mode_d;
    logic         tdone_q, tdone_d;
    logic         ddone_q, ddone_d;
    logic         arb_en;
    logic [1:0]   gnt;

    // Grant only from IDLE with the core drained; gating on inRst keeps every
    // output low for the whole time reset is held, not just after the next edge.
    assign arb_en = (state_q == ST_IDLE) && !inCoreBusy && !inRst;

    xts_rr_arb2 u_arb (
        .clk_i (inClk),
        .rst_i (inRst),
        .req_i ({inDataReq, inTweakReq}),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    assign outTweakGrant = gnt[0];
    assign outDataGrant  = gnt[1];
    assign outTweakDone  = tdone_q;
    assign outDataDone   = ddone_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        mode_d       = mode_q;
        tdone_d      = 1'b0;
        ddone_d      = 1'b0;
        outCoreStart = 1'b0;
        outCoreSel   = sel_q;
        outCoreMode  = mode_q;
        outBusy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    sel_d        = gnt[1] ? SEL_DATA : SEL_TWEAK;
                    mode_d       = gnt[1] ? inDataMode : MODE_ENC;
                    // Core samples sel/mode in the grant cycle itself, so present the new values now.
                    outCoreSel   = sel_d;
                    outCoreMode  = mode_d;
                    outCoreStart = 1'b1;
                    outBusy      = 1'b1;
                    cnt_d        = 4'd1;
                    state_d      = (mode_d == MODE_DEC) ? ST_HOLD : ST_RUN;
                end
            end
            ST_HOLD: begin
                // Decrypt input is captured at core counter 1, so strobe once more.
                outCoreStart = 1'b1;
                cnt_d        = cnt_q + 4'd1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == pRoundCount) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    tdone_d = (sel_q == SEL_TWEAK);
                    ddone_d = (sel_q == SEL_DATA);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= SEL_TWEAK;
            mode_q  <= MODE_ENC;
            tdone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            tdone_q <= tdone_d;
            ddone_q <= ddone_d;
        end
    end

endmodule
